// File: rtl/aes_pkg.sv
// Shared AES datapath types: column-major state, ShiftRows FSM states and row helpers.
// Rows are 32-bit words with column 0 in the top byte (FIPS-197 ordering).
package aes_pkg;

  typedef logic [3:0][3:0][7:0] aes_state_t;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_rows_state_e;

  // Forward rotates left by amt bytes; inverse rotates right by the same amount.
  function automatic logic [31:0] row_rot(input logic [31:0] row32, input logic [1:0] amt,
                                          input logic inv);
    logic [1:0]  left;
    logic [63:0] dbl;
    left = inv ? (2'd0 - amt) : amt;
    dbl  = {row32, row32};
    return dbl[63 - 8*int'(left) -: 32];
  endfunction

  // Byte (r,c) of the flat 128-bit block lives at element [3-c][3-r] of aes_state_t.
  function automatic logic [31:0] get_row(input aes_state_t s, input logic [1:0] r);
    logic [31:0] row32;
    for (int c = 0; c < 4; c++) row32[31-8*c -: 8] = s[2'(3-c)][2'd3-r];
    return row32;
  endfunction

  function automatic aes_state_t set_row(input aes_state_t s, input logic [1:0] r,
                                         input logic [31:0] row32);
    aes_state_t o;
    o = s;
    for (int c = 0; c < 4; c++) o[2'(3-c)][2'd3-r] = row32[31-8*c -: 8];
    return o;
  endfunction

endpackage

// File: rtl/aes_row_rotate.sv
// Combinational 32-bit AES row rotator; amount in bytes, direction forward/inverse.
// Zero latency, no state, no backpressure.
module aes_row_rotate
  import aes_pkg::*;
(
  input  logic [31:0] row_in,
  input  logic [1:0]  amt_in,
  input  logic        inv_in,
  output logic [31:0] row_out
);

  assign row_out = row_rot(row_in, amt_in, inv_in);

endmodule

// File: rtl/shift_rows_engine.sv
// AES ShiftRows/InvShiftRows stage, ROWS_PER_CYCLE rows per cycle; SHIFT_ROWS_PARITY_EN adds parity_out.
// Latency: out_valid rises 4/ROWS_PER_CYCLE edges after accept; one block per 4/ROWS_PER_CYCLE+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module shift_rows_engine
  import aes_pkg::*;
#(
  parameter int ROWS_PER_CYCLE = 1,
  parameter int TAG_W          = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     block_in,
  input  logic             inv_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     result_out,
  output logic [TAG_W-1:0] tag_out
`ifdef SHIFT_ROWS_PARITY_EN
  ,
  output logic [15:0]      parity_out
`endif
);

  if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4)) begin : g_bad_rpc
    $error("shift_rows_engine: ROWS_PER_CYCLE must be 1, 2 or 4");
  end

  shift_rows_state_e state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  aes_state_t        src_q, src_d;
  aes_state_t        work_q, work_d;
  logic              inv_q, inv_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  logic [ROWS_PER_CYCLE-1:0][31:0] rot_in;
  logic [ROWS_PER_CYCLE-1:0][31:0] rot_out;
  logic [ROWS_PER_CYCLE-1:0][1:0]  rot_row;

  // Each lane handles one row of the current batch; the row index is also its rotate amount.
  for (genvar k = 0; k < ROWS_PER_CYCLE; k++) begin : g_rot
    assign rot_row[k] = 2'(cnt_q + 3'(k));
    assign rot_in[k]  = get_row(src_q, rot_row[k]);
    aes_row_rotate u_rot (
      .row_in  (rot_in[k]),
      .amt_in  (rot_row[k]),
      .inv_in  (inv_q),
      .row_out (rot_out[k])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    work_d  = work_q;
    inv_d   = inv_q;
    tag_d   = tag_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = block_in;
          inv_d   = inv_in;
          tag_d   = tag_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        for (int k = 0; k < ROWS_PER_CYCLE; k++) work_d = set_row(work_d, rot_row[k], rot_out[k]);
        cnt_d = cnt_q + 3'(ROWS_PER_CYCLE);
        if (cnt_d == 3'd4) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      work_q  <= '0;
      inv_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
      tag_q   <= tag_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign result_out = work_q;
  assign tag_out    = tag_q;

`ifdef SHIFT_ROWS_PARITY_EN
  logic [15:0]  parity_q, parity_d;
  logic [127:0] work_flat;

  // Parity tracks the next work register so it lands on the same edge as the final row.
  assign work_flat = work_d;
  always_comb begin
    parity_d = '0;
    for (int i = 0; i < 16; i++) parity_d[i] = ^work_flat[8*i+7 -: 8];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) parity_q <= '0;
    else           parity_q <= parity_d;
  end

  assign parity_out = parity_q;
`endif

endmodule
